shift_reg_univ: RTL and testbench
=================================

Name: shift_reg_univ

Overview:
- Parametrised successor to the team's fixed 4-bit serial-in/serial-out shift register.
- Generalised to WIDTH bits, with parallel load and selectable shift/rotate mode.
- A counted-burst controller shifts exactly N times on a start command, then pulses done.
- Used as the serialiser/deserialiser and barrel-by-iteration element in datapath blocks.

Parameters:
- WIDTH, 8, register width in bits; must be >= 2.
- CNT_W, $clog2(WIDTH+1), width of the shift-count input and internal counter.

Ports:
- clk  in  1  rising-edge clock, sole clock domain
- clr  in  1  reset, synchronous, active-high; clears all state on the clk edge where it is 1
- load  in  1  parallel load request (IDLE only)
- pdata  in  WIDTH  parallel load data
- start  in  1  begin counted shift burst (IDLE only)
- mode  in  3  shift mode, sampled with start
- count  in  CNT_W  number of shifts in the burst, sampled with start
- si_r  in  1  serial input entering at MSB for right shifts
- si_l  in  1  serial input entering at LSB for left shifts
- q  out  WIDTH  register contents
- so_r  out  1  right-shift serial out = q[0], combinational from register
- so_l  out  1  left-shift serial out = q[WIDTH-1], combinational from register
- busy  out  1  high while a burst is in progress
- done  out  1  one-cycle pulse when a burst completes

Behaviour:
- Reset (clr=1 at an edge): q=0, state=IDLE, busy=0, done=0, counter=0, latched mode=0. clr overrides every other input, including mid-burst; the aborted burst produces no done.

Modes (one step per shift):
- 0 HOLD: no change.
- 1 SHR: q <= {si_r, q[W-1:1]}.
- 2 SHL: q <= {q[W-2:0], si_l}.
- 3 ROR: q <= {q[0], q[W-1:1]}.
- 4 ROL: q <= {q[W-2:0], q[W-1]}.
- 5 ASR: q <= {q[W-1], q[W-1:1]}.
- 6, 7: reserved, treated as HOLD. The burst still counts and still asserts done.

FSM states:
- IDLE
  - load=1: q <= pdata, stay IDLE.
  - else start=1 with count=0: done=1 next cycle, no shift, stay IDLE.
  - else start=1 with count>0: latch mode and count, go to RUN, busy=1.
  - load and start in the same cycle: load wins and start is dropped.
- RUN: every edge performs one shift using the latched mode, then counter--.
  - On the edge where counter==1 (last shift): go to IDLE, busy=0, done=1 for exactly one cycle.
  - load, start, mode and count inputs are ignored in RUN.
  - si_r and si_l are sampled live on every shift edge.

Timing:
- start sampled at edge E0; shifts occur at E1..EN; busy is high from after E0 until after EN; done is high for the cycle after EN.
- Back-to-back start is accepted on the cycle done is high, since state is already IDLE.
- count values above WIDTH are legal; the register shifts count times (e.g. ROR by WIDTH+1 equals ROR by 1).
- done is 0 in every cycle other than the completion cycle.
- All outputs except so_r and so_l are registered.

Decomposition:
- Shared package shift_pkg holds:
  - mode localparams MODE_HOLD, MODE_SHR, MODE_SHL, MODE_ROR, MODE_ROL, MODE_ASR;
  - FSM state encoding ST_IDLE, ST_RUN.
- One natural sub-module, shift_step: a combinational next-value function taking (q, mode, si_r, si_l) and returning the shifted word.
- The top level holds the FSM, the counter and the q register.

Test Plan:
- Reset: clr=1 during a burst (WIDTH=8, q=8'hA5, SHR, count=5, clr at E2) -> next edge q=0, busy=0, no done pulse ever follows.
- Load then SHR: load pdata=8'hB4, start SHR count=3 with si_r=1 -> q=8'hF6 after E3; done high one cycle; busy high for 3 cycles.
- ROL wrap: q=8'h81, ROL count=9 -> q=8'h03 (same as ROL 1); busy high for 9 cycles.
- ASR sign extend: q=8'h90, ASR count=2 -> q=8'hE4; so_r follows q[0] each cycle (0,0,0).
- Edge cases, all three must hold:
  - count=0 -> done at the next cycle, q unchanged, busy never asserts.
  - load and start together -> q=pdata, no burst.
  - start during RUN -> ignored.
- Back-to-back bursts: second start on the done cycle, SHL count=2 with si_l=1 after SHL count=1 from q=8'h01 -> q sequence 02, 05, 0B; done pulses at two separate cycles.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared constants for the universal shift register: shift modes and FSM state encoding.
package shift_pkg;

    localparam int unsigned MODE_W = 3;
    localparam int unsigned ST_W   = 1;

    // One step of the selected operation; codes 6 and 7 behave as HOLD.
    localparam logic [MODE_W-1:0] MODE_HOLD = 3'd0;
    localparam logic [MODE_W-1:0] MODE_SHR  = 3'd1;
    localparam logic [MODE_W-1:0] MODE_SHL  = 3'd2;
    localparam logic [MODE_W-1:0] MODE_ROR  = 3'd3;
    localparam logic [MODE_W-1:0] MODE_ROL  = 3'd4;
    localparam logic [MODE_W-1:0] MODE_ASR  = 3'd5;

    localparam logic [ST_W-1:0] ST_IDLE = 1'b0;
    localparam logic [ST_W-1:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/shift_reg_univ_if.sv
// Control/data bundle of shift_reg_univ.
// master: load, pdata, start, mode, count, si_r, si_l out; q, so_r, so_l, busy, done in.
// slave : the mirror image, used by the register itself.
interface shift_reg_univ_if
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
);
    logic              load;
    logic [WIDTH-1:0]  pdata;
    logic              start;
    logic [MODE_W-1:0] mode;
    logic [CNT_W-1:0]  count;
    logic              si_r;
    logic              si_l;
    logic [WIDTH-1:0]  q;
    logic              so_r;
    logic              so_l;
    logic              busy;
    logic              done;

    modport master (
        output load, pdata, start, mode, count, si_r, si_l,
        input  q, so_r, so_l, busy, done
    );

    modport slave (
        input  load, pdata, start, mode, count, si_r, si_l,
        output q, so_r, so_l, busy, done
    );
endinterface

// File: rtl/shift_step.sv
// Combinational single-step shifter: returns q after one operation of the given mode.
// Ports: q (current word), mode, si_r (MSB fill for SHR), si_l (LSB fill for SHL) -> nxt.
module shift_step
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0]  q,
    input  logic [MODE_W-1:0] mode,
    input  logic              si_r,
    input  logic              si_l,
    output logic [WIDTH-1:0]  nxt
);

    // Reserved codes fall into the default and leave the word untouched.
    always_comb begin
        nxt = q;
        case (mode)
            MODE_HOLD: nxt = q;
            MODE_SHR:  nxt = {si_r, q[WIDTH-1:1]};
            MODE_SHL:  nxt = {q[WIDTH-2:0], si_l};
            MODE_ROR:  nxt = {q[0], q[WIDTH-1:1]};
            MODE_ROL:  nxt = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ASR:  nxt = {q[WIDTH-1], q[WIDTH-1:1]};
            default:   nxt = q;
        endcase
    end

endmodule

// File: rtl/shift_reg_univ.sv
// Universal WIDTH-bit shift register with parallel load and counted shift bursts.
// Ports: clk, clr (sync active-high clear), bus (slave side of shift_reg_univ_if):
//   load/pdata parallel load, start/mode/count burst request, si_r/si_l serial in,
//   q register, so_r/so_l serial out, busy during a burst, done one-cycle completion pulse.
module shift_reg_univ
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  clr,
    shift_reg_univ_if.slave       bus
);

    logic [ST_W-1:0]   state, state_n;
    logic [WIDTH-1:0]  q_r, q_n;
    logic [CNT_W-1:0]  cnt_r, cnt_n;
    logic [MODE_W-1:0] mode_r, mode_n;
    logic              busy_r, busy_n;
    logic              done_r, done_n;
    logic [WIDTH-1:0]  step_q;

    // Next word for one shift with the mode latched at start.
    shift_step #(.WIDTH(WIDTH)) u_step (
        .q    (q_r),
        .mode (mode_r),
        .si_r (bus.si_r),
        .si_l (bus.si_l),
        .nxt  (step_q)
    );

    // State and datapath registers; clr wins over everything, including a running burst.
    always_ff @(posedge clk) begin
        if (clr) begin
            state  <= ST_IDLE;
            q_r    <= '0;
            cnt_r  <= '0;
            mode_r <= MODE_HOLD;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            state  <= state_n;
            q_r    <= q_n;
            cnt_r  <= cnt_n;
            mode_r <= mode_n;
            busy_r <= busy_n;
            done_r <= done_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n = state;
        q_n     = q_r;
        cnt_n   = cnt_r;
        mode_n  = mode_r;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        case (state)
            ST_IDLE: begin
                // Load takes priority; a simultaneous start is dropped.
                if (bus.load) begin
                    q_n = bus.pdata;
                end else if (bus.start) begin
                    if (bus.count == '0) begin
                        done_n = 1'b1;
                    end else begin
                        mode_n  = bus.mode;
                        cnt_n   = bus.count;
                        state_n = ST_RUN;
                        busy_n  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                q_n   = step_q;
                cnt_n = cnt_r - CNT_W'(1);
                if (cnt_r == CNT_W'(1)) begin
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                end else begin
                    busy_n = 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign bus.q    = q_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.so_r = q_r[0];
    assign bus.so_l = q_r[WIDTH-1];

endmodule

// File: tb/tb_shift_reg_univ.sv
// Self-checking bench for shift_reg_univ: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_shift_reg_univ;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = $clog2(W + 1);

    logic clk;
    logic clr;

    shift_reg_univ_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    shift_reg_univ #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: remaining shifts (0 = idle), latched mode, visible outputs.
    logic [W-1:0] m_q;
    int           m_rem;
    int           m_mode;
    logic         m_busy;
    logic         m_done;

    // One operation, written with arithmetic shifts rather than bit concatenation.
    function automatic logic [W-1:0] ref_op(logic [W-1:0] v, int md, logic sr, logic sl);
        case (md)
            1:       return (v >> 1) | (W'(sr) << (W - 1));
            2:       return (v << 1) | W'(sl);
            3:       return (v >> 1) | (v << (W - 1));
            4:       return (v << 1) | (v >> (W - 1));
            5:       return W'($signed(v) >>> 1);
            default: return v;
        endcase
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        if (clr) begin
            m_q = '0; m_rem = 0; m_mode = 0; m_busy = 1'b0; m_done = 1'b0;
        end else if (m_rem == 0) begin
            m_done = 1'b0;
            m_busy = 1'b0;
            if (bus.load) begin
                m_q = bus.pdata;
            end else if (bus.start) begin
                if (int'(bus.count) == 0) begin
                    m_done = 1'b1;
                end else begin
                    m_rem  = int'(bus.count);
                    m_mode = int'(bus.mode);
                    m_busy = 1'b1;
                end
            end
        end else begin
            m_q    = ref_op(m_q, m_mode, bus.si_r, bus.si_l);
            m_rem  = m_rem - 1;
            m_busy = (m_rem != 0);
            m_done = (m_rem == 0);
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Clock once, then compare every output with the model.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("q",    32'(bus.q),    32'(m_q));
        chk("busy", 32'(bus.busy), 32'(m_busy));
        chk("done", 32'(bus.done), 32'(m_done));
        chk("so_r", 32'(bus.so_r), 32'(m_q[0]));
        chk("so_l", 32'(bus.so_l), 32'(m_q[W-1]));
    endtask

    task automatic quiet();
        bus.load = 1'b0; bus.start = 1'b0;
    endtask

    task automatic do_load(logic [W-1:0] v);
        bus.load = 1'b1; bus.pdata = v; tick(); quiet();
    endtask

    task automatic do_start(int md, int n);
        bus.start = 1'b1; bus.mode = 3'(md); bus.count = CW'(n); tick(); quiet();
    endtask

    initial begin
        int busy_cycles;
        int guard;
        clr = 1'b1;
        bus.load = 1'b0; bus.pdata = '0; bus.start = 1'b0; bus.mode = '0;
        bus.count = '0; bus.si_r = 1'b0; bus.si_l = 1'b0;
        m_q = '0; m_rem = 0; m_mode = 0; m_busy = 1'b0; m_done = 1'b0;
        @(negedge clk);
        tick(); tick();
        chk("reset_q", 32'(bus.q), 32'h0);
        clr = 1'b0;

        // Load then SHR by 3 with si_r=1.
        do_load(8'hB4);
        bus.si_r = 1'b1;
        do_start(1, 3);
        busy_cycles = 1;
        tick(); busy_cycles += int'(bus.busy);
        tick(); busy_cycles += int'(bus.busy);
        tick();
        chk("shr_q", 32'(bus.q), 32'hF6);
        chk("shr_done", 32'(bus.done), 32'h1);
        chk("shr_busy_cycles", 32'(busy_cycles), 32'd3);
        tick();
        chk("shr_done_off", 32'(bus.done), 32'h0);

        // ROL by 9 wraps to ROL by 1.
        do_load(8'h81);
        do_start(4, 9);
        busy_cycles = 1;
        guard = 0;
        while (!bus.done && guard < 40) begin
            tick(); busy_cycles += int'(bus.busy); guard++;
        end
        chk("rol_done_seen", 32'(bus.done), 32'h1);
        chk("rol_q", 32'(bus.q), 32'h03);
        chk("rol_busy_cycles", 32'(busy_cycles), 32'd9);

        // ASR sign extension; so_r stays 0 throughout.
        do_load(8'h90);
        do_start(5, 2);
        chk("asr_so_r0", 32'(bus.so_r), 32'h0);
        tick();
        chk("asr_so_r1", 32'(bus.so_r), 32'h0);
        tick();
        chk("asr_so_r2", 32'(bus.so_r), 32'h0);
        chk("asr_q", 32'(bus.q), 32'hE4);

        // count=0: immediate done, no shift, no busy.
        do_load(8'h3C);
        do_start(3, 0);
        chk("cnt0_done", 32'(bus.done), 32'h1);
        chk("cnt0_busy", 32'(bus.busy), 32'h0);
        chk("cnt0_q", 32'(bus.q), 32'h3C);
        tick();

        // load and start together: load wins.
        bus.load = 1'b1; bus.pdata = 8'h5A; bus.start = 1'b1; bus.mode = 3'd1; bus.count = CW'(4);
        tick(); quiet();
        chk("ldst_q", 32'(bus.q), 32'h5A);
        chk("ldst_busy", 32'(bus.busy), 32'h0);
        tick();
        chk("ldst_no_burst", 32'(bus.busy), 32'h0);

        // start/load while running are ignored.
        do_start(3, 3);
        bus.start = 1'b1; bus.mode = 3'd2; bus.count = CW'(7); bus.load = 1'b1; bus.pdata = 8'hFF;
        tick(); tick();
        quiet();
        tick();
        chk("run_ign_q", 32'(bus.q), 32'h4B);
        chk("run_ign_done", 32'(bus.done), 32'h1);

        // Back-to-back SHL bursts.
        do_load(8'h01);
        bus.si_l = 1'b0;
        do_start(2, 1);
        tick();
        chk("b2b_q1", 32'(bus.q), 32'h02);
        chk("b2b_done1", 32'(bus.done), 32'h1);
        bus.si_l = 1'b1;
        do_start(2, 2);
        chk("b2b_done_gap", 32'(bus.done), 32'h0);
        tick();
        chk("b2b_q2", 32'(bus.q), 32'h05);
        tick();
        chk("b2b_q3", 32'(bus.q), 32'h0B);
        chk("b2b_done2", 32'(bus.done), 32'h1);

        // clr mid-burst aborts without done.
        do_load(8'hA5);
        do_start(1, 5);
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("abort_q", 32'(bus.q), 32'h0);
        chk("abort_busy", 32'(bus.busy), 32'h0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("abort_no_done", 32'(bus.done), 32'h0);
        end

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            clr       = ($urandom_range(0, 49) == 0);
            bus.load  = ($urandom_range(0, 5) == 0);
            bus.start = ($urandom_range(0, 2) == 0);
            bus.pdata = W'($urandom);
            bus.mode  = 3'($urandom_range(0, 7));
            bus.count = CW'($urandom_range(0, (1 << CW) - 1));
            bus.si_r  = 1'($urandom);
            bus.si_l  = 1'($urandom);
            tick();
        end
        clr = 1'b0;
        quiet();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
